apb_master_arbiter: RTL and testbench

Shares the single SoC peripheral APB bus (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC ctrl, debug, SPI accel, 7-seg, audio PWM) between several on-chip requesters, e.g. the core data bridge and a debug/DMA port. Requests are granted round-robin. Each granted request becomes one standard APB SETUP/ACCESS transfer. A per-transfer timeout terminates any access whose slave never asserts `pready`. The block sits between the requesters and the APB address decoder, and drives the decoder through the `APB_BUS` Master modport.

---
 rtl/apb_arb_pkg.sv | 18 +
 rtl/apb_rr_arb.sv | 55 +++++
 rtl/apb_master_arbiter.sv | 171 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_arb_state_e;

    // Width of a counter able to reach t; never narrower than one bit.
    function automatic int cnt_width(input int t);
        if (t <= 0) begin
            return 1;
        end
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_rr_arb.sv
// Round-robin arbiter: search starts at the pointer and wraps upward;
// the pointer moves to winner+1 whenever a grant is taken.
module apb_rr_arb #(
    parameter int NB_REQ = 2,
    parameter int IDX_W  = $clog2(NB_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NB_REQ-1:0] i_req,
    input  logic              i_advance,
    output logic [NB_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx
);

    logic [IDX_W-1:0]  r_ptr;
    logic [NB_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_j;
    logic              w_found;
    int                w_sum;

    // First requester at or after the pointer wins.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_j     = '0;
        w_found = 1'b0;
        w_sum   = 0;
        for (int k = 0; k < NB_REQ; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NB_REQ) begin
                w_sum = w_sum - NB_REQ;
            end
            w_j = IDX_W'(w_sum);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                w_gnt[w_j] = 1'b1;
                w_idx      = w_j;
            end
        end
    end

    // Pointer advances past the winner on each accepted grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (w_idx == IDX_W'(NB_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB bus between NB_REQ requesters; one APB transfer per grant,
// with an optional ACCESS-phase timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | bus idle; grant winner, capture its request fields
// ST_SETUP  | psel=1, penable=0 for one cycle
// ST_ACCESS | psel=1, penable=1 until pready or timeout
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NB_REQ         = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NB_REQ-1:0]                  req_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
    input  logic [NB_REQ-1:0]                  we_i,
    output logic [NB_REQ-1:0]                  gnt_o,
    output logic [NB_REQ-1:0]                  rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]          rdata_o,
    output logic                               err_o,
    output logic [APB_ADDR_WIDTH-1:0]          paddr,
    output logic [APB_DATA_WIDTH-1:0]          pwdata,
    output logic                               pwrite,
    output logic                               psel,
    output logic                               penable,
    input  logic [APB_DATA_WIDTH-1:0]          prdata,
    input  logic                               pready,
    input  logic                               pslverr
);

    localparam int IDX_W = $clog2(NB_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

    apb_arb_state_e              r_state;
    apb_arb_state_e              w_state_nxt;
    logic [APB_ADDR_WIDTH-1:0]   r_paddr;
    logic [APB_DATA_WIDTH-1:0]   r_pwdata;
    logic                        r_pwrite;
    logic [IDX_W-1:0]            r_owner;
    logic [CNT_W-1:0]            r_cnt;
    logic [NB_REQ-1:0]           r_rvalid;
    logic [APB_DATA_WIDTH-1:0]   r_rdata;
    logic                        r_err;

    logic [NB_REQ-1:0]           w_arb_req;
    logic                        w_advance;
    logic [NB_REQ-1:0]           w_gnt;
    logic [IDX_W-1:0]            w_idx;
    logic                        w_psel;
    logic                        w_penable;
    logic                        w_to_hit;
    logic [NB_REQ-1:0]           w_owner_oh;

    // Requests only compete while the bus is idle, so the owner's own
    // req_i has no effect until its transfer has completed.
    apb_rr_arb #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IDX_W)
    ) u_rr_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_arb_req),
        .i_advance (w_advance),
        .o_gnt     (w_gnt),
        .o_idx     (w_idx)
    );

    assign w_to_hit   = (TIMEOUT != 0) && (r_cnt == TO_C);
    assign w_owner_oh = NB_REQ'(1) << r_owner;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and APB control decode; pready beats the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_arb_req   = '0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb_req = req_i;
                w_advance = |req_i;
                if (|req_i) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_psel      = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (pready || w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture, wait counter and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_advance) begin
                        r_paddr  <= addr_i[int'(w_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                        r_pwdata <= wdata_i[int'(w_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                        r_pwrite <= we_i[w_idx];
                        r_owner  <= w_idx;
                        r_cnt    <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_rvalid <= w_owner_oh;
                        r_rdata  <= r_pwrite ? '0 : prdata;
                        r_err    <= pslverr;
                    end else if (w_to_hit) begin
                        r_rvalid <= w_owner_oh;
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                    end else if ((TIMEOUT != 0) && (r_cnt != TO_C)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;
    assign paddr    = r_paddr;
    assign pwdata   = r_pwdata;
    assign pwrite   = r_pwrite;
    assign psel     = w_psel;
    assign penable  = w_penable;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with two requesters and TIMEOUT=8.
// Cycle N below means the interval just after the N-th rising edge
// following the grant cycle (cycle 0).
module tb_apb_master_arbiter;

    localparam int NB = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     req_i;
    logic [NB*AW-1:0]  addr_i;
    logic [NB*DW-1:0]  wdata_i;
    logic [NB-1:0]     we_i;
    logic [NB-1:0]     gnt_o;
    logic [NB-1:0]     rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    int n_tests = 0;
    int n_fail  = 0;

    apb_master_arbiter #(
        .NB_REQ         (NB),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT        (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .we_i     (we_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        addr_i[r*AW +: AW]  = a;
        wdata_i[r*DW +: DW] = d;
        we_i[r]             = w;
    endtask

    logic [NB-1:0] exp_oh   [4];
    logic [AW-1:0] exp_addr [4];

    initial begin
        rst     = 1'b1;
        req_i   = '0;
        addr_i  = '0;
        wdata_i = '0;
        we_i    = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_o, 0);
        rst = 1'b0;
        tick();

        // Single zero-wait read by requester 0
        set_req(0, 32'h1A10_1000, 32'h0, 1'b0);
        req_i = 2'b01;
        #1;
        chk("t1_gnt_c0", gnt_o, 2'b01);
        chk("t1_psel_c0", psel, 0);
        tick();
        req_i  = 2'b00;
        pready = 1'b1;
        prdata = 32'hDEAD_BEEF;
        chk("t1_psel_c1", psel, 1);
        chk("t1_penable_c1", penable, 0);
        chk("t1_paddr_c1", paddr, 32'h1A10_1000);
        chk("t1_pwrite_c1", pwrite, 0);
        tick();
        chk("t1_penable_c2", penable, 1);
        chk("t1_rvalid_c2", rvalid_o, 0);
        tick();
        chk("t1_rvalid_c3", rvalid_o, 2'b01);
        chk("t1_rdata_c3", rdata_o, 32'hDEAD_BEEF);
        chk("t1_err_c3", err_o, 0);
        chk("t1_psel_c3", psel, 0);

        // Contention: pointer sits at 1 after the previous grant
        exp_oh[0] = 2'b10; exp_oh[1] = 2'b01; exp_oh[2] = 2'b10; exp_oh[3] = 2'b01;
        exp_addr[0] = 32'h200; exp_addr[1] = 32'h100; exp_addr[2] = 32'h200; exp_addr[3] = 32'h100;
        set_req(0, 32'h100, 32'h0, 1'b0);
        set_req(1, 32'h200, 32'h0, 1'b0);
        prdata = 32'h1111_2222;
        req_i  = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cont_gnt_%0d", k), gnt_o, exp_oh[k]);
            if (k > 0) begin
                chk($sformatf("cont_rvalid_%0d", k - 1), rvalid_o, exp_oh[k - 1]);
            end
            tick();
            if (k == 3) begin
                req_i = 2'b00;
            end
            chk($sformatf("cont_paddr_%0d", k), paddr, exp_addr[k]);
            chk($sformatf("cont_gnt_setup_%0d", k), gnt_o, 0);
            tick();
            chk($sformatf("cont_penable_%0d", k), penable, 1);
            chk($sformatf("cont_gnt_access_%0d", k), gnt_o, 0);
            tick();
        end
        chk("cont_rvalid_3", rvalid_o, 2'b01);
        chk("cont_rdata_3", rdata_o, 32'h1111_2222);
        chk("cont_gnt_end", gnt_o, 0);

        // Write with four wait states; pointer is at 1
        set_req(1, 32'h1A10_3004, 32'h0000_00A5, 1'b1);
        req_i  = 2'b10;
        pready = 1'b0;
        prdata = 32'hFFFF_FFFF;
        #1;
        chk("ws_gnt", gnt_o, 2'b10);
        tick();
        req_i = 2'b00;
        chk("ws_paddr_c1", paddr, 32'h1A10_3004);
        chk("ws_pwdata_c1", pwdata, 32'h0000_00A5);
        chk("ws_pwrite_c1", pwrite, 1);
        chk("ws_penable_c1", penable, 0);
        for (int c = 2; c < 6; c++) begin
            tick();
            chk($sformatf("ws_paddr_c%0d", c), paddr, 32'h1A10_3004);
            chk($sformatf("ws_pwdata_c%0d", c), pwdata, 32'h0000_00A5);
            chk($sformatf("ws_pwrite_c%0d", c), pwrite, 1);
            chk($sformatf("ws_penable_c%0d", c), penable, 1);
            chk($sformatf("ws_rvalid_c%0d", c), rvalid_o, 0);
        end
        tick();
        chk("ws_paddr_c6", paddr, 32'h1A10_3004);
        chk("ws_rvalid_c6", rvalid_o, 0);
        pready = 1'b1;
        tick();
        chk("ws_rvalid_c7", rvalid_o, 2'b10);
        chk("ws_rdata_c7", rdata_o, 0);
        chk("ws_err_c7", err_o, 0);
        chk("ws_paddr_hold", paddr, 32'h1A10_3004);

        // Slave error on a read; pointer is at 0
        set_req(0, 32'h1A10_2000, 32'h0, 1'b0);
        req_i   = 2'b01;
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h0000_1234;
        #1;
        chk("se_gnt", gnt_o, 2'b01);
        tick();
        req_i = 2'b00;
        tick();
        tick();
        chk("se_rvalid", rvalid_o, 2'b01);
        chk("se_err", err_o, 1);
        chk("se_rdata", rdata_o, 32'h0000_1234);
        pslverr = 1'b0;

        // Timeout: pready never asserted; pointer is at 1
        set_req(1, 32'h1A10_4000, 32'h0, 1'b0);
        req_i  = 2'b10;
        pready = 1'b0;
        prdata = 32'h5555_AAAA;
        #1;
        chk("to_gnt", gnt_o, 2'b10);
        tick();
        req_i = 2'b00;
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk($sformatf("to_rvalid_c%0d", c), rvalid_o, 0);
        end
        chk("to_penable_c10", penable, 1);
        tick();
        chk("to_rvalid_c11", rvalid_o, 2'b10);
        chk("to_err_c11", err_o, 1);
        chk("to_rdata_c11", rdata_o, 0);
        chk("to_psel_c11", psel, 0);

        // pready arrives in the cycle the timeout would fire; pointer is at 0
        set_req(0, 32'h1A10_5000, 32'h0, 1'b0);
        req_i  = 2'b01;
        pready = 1'b0;
        prdata = 32'hCAFE_F00D;
        #1;
        chk("tr_gnt", gnt_o, 2'b01);
        tick();
        req_i = 2'b00;
        for (int c = 2; c <= 9; c++) begin
            tick();
            chk($sformatf("tr_rvalid_c%0d", c), rvalid_o, 0);
        end
        tick();
        chk("tr_penable_c10", penable, 1);
        chk("tr_rvalid_c10", rvalid_o, 0);
        pready = 1'b1;
        tick();
        chk("tr_rvalid_c11", rvalid_o, 2'b01);
        chk("tr_err_c11", err_o, 0);
        chk("tr_rdata_c11", rdata_o, 32'hCAFE_F00D);
        pready = 1'b0;

        // Reset during ACCESS; pointer is at 1 before the reset
        set_req(1, 32'h1A10_6000, 32'h0, 1'b0);
        req_i = 2'b10;
        #1;
        chk("rm_gnt", gnt_o, 2'b10);
        tick();
        req_i = 2'b00;
        tick();
        chk("rm_penable_c2", penable, 1);
        rst = 1'b1;
        tick();
        chk("rm_psel_c3", psel, 0);
        chk("rm_penable_c3", penable, 0);
        chk("rm_rvalid_c3", rvalid_o, 0);
        chk("rm_paddr_c3", paddr, 0);
        rst = 1'b0;
        tick();
        chk("rm_rvalid_c4", rvalid_o, 0);
        set_req(0, 32'h1A10_7000, 32'h0, 1'b0);
        set_req(1, 32'h1A10_8000, 32'h0, 1'b0);
        req_i = 2'b11;
        #1;
        chk("rm_gnt_after", gnt_o, 2'b01);
        tick();
        req_i = 2'b00;
        chk("rm_paddr_after", paddr, 32'h1A10_7000);
        chk("rm_rvalid_after", rvalid_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
